// File: rtl/bellek_yanitlayici.sv
// Memory-side bus responder: word-organised storage with a programmable wait-state
// latency and a one-cycle ready pulse, used to exercise the CPU stall path.
module bellek_yanitlayici #(
    parameter int                   ADRES_BIT    = 32,
    parameter logic [ADRES_BIT-1:0] BELLEK_ADRES = 32'h8000_0000,
    parameter int                   VERI_BIT     = 32,
    parameter int                   SATIR_SAYISI = 1024,
    parameter int                   GECIKME      = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 istek,
    input  logic [ADRES_BIT-1:0] adres,
    input  logic                 yaz_gecerli,
    input  logic [VERI_BIT-1:0]  yaz_veri,
    output logic [VERI_BIT-1:0]  oku_veri,
    output logic                 hazir,
    output logic                 hata
);

    // state | meaning
    // BOSTA | idle, accepts istek
    // BEKLE | wait states, sayac counts down to 1
    // YANIT | respond, hazir high for one cycle

    localparam int BAYT_BIT  = $clog2(VERI_BIT / 8);
    localparam int SATIR_BIT = $clog2(SATIR_SAYISI);

    typedef enum logic [1:0] {BOSTA, BEKLE, YANIT} durum_t;

    durum_t durum, durum_sonraki;

    logic [VERI_BIT-1:0]  bellek [0:SATIR_SAYISI-1];

    logic [3:0]           sayac;
    logic [ADRES_BIT-1:0] adres_r;
    logic                 yaz_r;
    logic [VERI_BIT-1:0]  veri_r;
    logic                 hata_r;

    logic                 yakala;
    logic                 giris_yanit;
    logic [ADRES_BIT-1:0] erisim_adres;
    logic                 erisim_yaz;
    logic [VERI_BIT-1:0]  erisim_veri;
    logic [ADRES_BIT-1:0] satir_no;
    logic [SATIR_BIT-1:0] satir;
    logic                 erisim_hata;

    // With zero wait states the access happens on the accepting edge, so the
    // live bus values are used instead of the not-yet-captured copies.
    assign erisim_adres = (durum == BOSTA) ? adres       : adres_r;
    assign erisim_yaz   = (durum == BOSTA) ? yaz_gecerli : yaz_r;
    assign erisim_veri  = (durum == BOSTA) ? yaz_veri    : veri_r;

    assign satir_no    = (erisim_adres - BELLEK_ADRES) >> BAYT_BIT;
    assign satir       = satir_no[SATIR_BIT-1:0];
    assign erisim_hata = (erisim_adres < BELLEK_ADRES)
                       || (satir_no >= ADRES_BIT'(SATIR_SAYISI))
                       || (erisim_adres[BAYT_BIT-1:0] != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            durum <= BOSTA;
        end else begin
            durum <= durum_sonraki;
        end
    end

    always_comb begin
        durum_sonraki = durum;
        yakala        = 1'b0;
        giris_yanit   = 1'b0;
        case (durum)
            BOSTA: begin
                if (istek) begin
                    yakala = 1'b1;
                    if (GECIKME == 0) begin
                        durum_sonraki = YANIT;
                        giris_yanit   = 1'b1;
                    end else begin
                        durum_sonraki = BEKLE;
                    end
                end
            end
            BEKLE: begin
                if (sayac == 4'd1) begin
                    durum_sonraki = YANIT;
                    giris_yanit   = 1'b1;
                end
            end
            YANIT:   durum_sonraki = BOSTA;
            default: durum_sonraki = BOSTA;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sayac   <= 4'd0;
            adres_r <= '0;
            yaz_r   <= 1'b0;
            veri_r  <= '0;
        end else if (yakala) begin
            sayac   <= 4'(GECIKME);
            adres_r <= adres;
            yaz_r   <= yaz_gecerli;
            veri_r  <= yaz_veri;
        end else if (durum == BEKLE) begin
            sayac <= sayac - 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            oku_veri <= '0;
            hata_r   <= 1'b0;
        end else if (giris_yanit) begin
            oku_veri <= erisim_hata ? '0 : bellek[satir];
            hata_r   <= erisim_hata;
        end
    end

    // Contents survive reset; rst gating keeps a zero-wait write from landing during reset.
    always_ff @(posedge clk) begin
        if (!rst && giris_yanit && erisim_yaz && !erisim_hata) begin
            bellek[satir] <= erisim_veri;
        end
    end

    assign hazir = (durum == YANIT);
    assign hata  = hazir & hata_r;

endmodule

// File: tb/tb_bellek_yanitlayici.sv
// Directed bench: four responders with different wait-state counts share one bus
// stimulus; each check targets the outputs of one selected instance.
module tb_bellek_yanitlayici;

    localparam int GK [4] = '{2, 0, 3, 15};

    logic        clk;
    logic        rst;
    logic        istek;
    logic [31:0] adres;
    logic        yaz_gecerli;
    logic [31:0] yaz_veri;
    logic [31:0] rd [4];
    logic        hz [4];
    logic        ht [4];

    int checks = 0;
    int errors = 0;

    bellek_yanitlayici #(.GECIKME(2)) u_g2 (
        .clk(clk), .rst(rst), .istek(istek), .adres(adres), .yaz_gecerli(yaz_gecerli),
        .yaz_veri(yaz_veri), .oku_veri(rd[0]), .hazir(hz[0]), .hata(ht[0]));
    bellek_yanitlayici #(.GECIKME(0)) u_g0 (
        .clk(clk), .rst(rst), .istek(istek), .adres(adres), .yaz_gecerli(yaz_gecerli),
        .yaz_veri(yaz_veri), .oku_veri(rd[1]), .hazir(hz[1]), .hata(ht[1]));
    bellek_yanitlayici #(.GECIKME(3)) u_g3 (
        .clk(clk), .rst(rst), .istek(istek), .adres(adres), .yaz_gecerli(yaz_gecerli),
        .yaz_veri(yaz_veri), .oku_veri(rd[2]), .hazir(hz[2]), .hata(ht[2]));
    bellek_yanitlayici #(.GECIKME(15)) u_g15 (
        .clk(clk), .rst(rst), .istek(istek), .adres(adres), .yaz_gecerli(yaz_gecerli),
        .yaz_veri(yaz_veri), .oku_veri(rd[3]), .hazir(hz[3]), .hata(ht[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          sel;
        logic [31:0] a;
        logic        we;
        logic [31:0] wd;
        logic [31:0] rd;
        logic        err;
    } vek_t;

    vek_t vek [9];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic yukle(input int i, input logic [31:0] v);
        u_g2.bellek[i]  = v;
        u_g0.bellek[i]  = v;
        u_g3.bellek[i]  = v;
        u_g15.bellek[i] = v;
    endtask

    task automatic erisim(input int sel, input logic [31:0] a, input logic we,
                          input logic [31:0] wd, input logic [31:0] exp_rd,
                          input logic exp_err, input bit karistir);
        int bulunan;
        @(posedge clk); #1;
        istek = 1'b1; adres = a; yaz_gecerli = we; yaz_veri = wd;
        @(posedge clk); #1;
        istek = 1'b0;
        if (karistir) begin
            adres = 32'h8000_0008; yaz_gecerli = 1'b0; yaz_veri = 32'h0;
        end
        bulunan = -1;
        for (int j = 0; j < 40; j++) begin
            @(negedge clk);
            if (hz[sel]) begin
                bulunan = j;
                break;
            end
        end
        chk($sformatf("latency g%0d", GK[sel]), 32'(bulunan + 1), 32'(GK[sel] + 1));
        if (bulunan >= 0) begin
            chk($sformatf("oku_veri g%0d @%h", GK[sel], a), rd[sel], exp_rd);
            chk($sformatf("hata g%0d @%h", GK[sel], a), 32'(ht[sel]), 32'(exp_err));
            @(negedge clk);
            chk($sformatf("hazir pulse width g%0d", GK[sel]), 32'(hz[sel]), 32'd0);
        end
        repeat (20) @(posedge clk);
    endtask

    initial begin
        int t0 [3];
        int t1 [3];
        int n0, n1;
        int say [4];

        rst = 1'b1; istek = 1'b0; adres = '0; yaz_gecerli = 1'b0; yaz_veri = '0;
        yukle(0, 32'haae0_0893);
        yukle(1, 32'h1720_0e93);
        yukle(2, 32'h0000_2222);
        yukle(3, 32'h3333_3333);
        yukle(1023, 32'hffff_0000);

        vek[0] = '{0, 32'h8000_0000, 1'b0, 32'h0,         32'haae0_0893, 1'b0};
        vek[1] = '{1, 32'h8000_0004, 1'b1, 32'hdead_beef, 32'h1720_0e93, 1'b0};
        vek[2] = '{1, 32'h8000_0004, 1'b0, 32'h0,         32'hdead_beef, 1'b0};
        vek[3] = '{0, 32'h7fff_fffc, 1'b0, 32'h0,         32'h0,         1'b1};
        vek[4] = '{0, 32'h8000_1000, 1'b1, 32'h5555_5555, 32'h0,         1'b1};
        vek[5] = '{1, 32'h8000_0002, 1'b0, 32'h0,         32'h0,         1'b1};
        vek[6] = '{2, 32'h8000_0ffc, 1'b0, 32'h0,         32'hffff_0000, 1'b0};
        vek[7] = '{3, 32'h8000_0008, 1'b0, 32'h0,         32'h0000_2222, 1'b0};
        vek[8] = '{1, 32'h8000_000c, 1'b0, 32'h0,         32'h3333_3333, 1'b0};

        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int s = 0; s < 4; s++) begin
            chk($sformatf("reset hazir g%0d", GK[s]), 32'(hz[s]), 32'd0);
            chk($sformatf("reset hata g%0d", GK[s]), 32'(ht[s]), 32'd0);
            chk($sformatf("reset oku_veri g%0d", GK[s]), rd[s], 32'd0);
        end
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 9; i++)
            erisim(vek[i].sel, vek[i].a, vek[i].we, vek[i].wd, vek[i].rd, vek[i].err, 1'b0);

        chk("errored write left bellek[0]", u_g2.bellek[0], 32'haae0_0893);
        chk("errored write left bellek[1]", u_g2.bellek[1], 32'hdead_beef);
        chk("errored write left bellek[1023]", u_g2.bellek[1023], 32'hffff_0000);

        // Captured operands must win over bus changes made during BEKLE.
        erisim(0, 32'h8000_0004, 1'b1, 32'h0bad_f00d, 32'hdead_beef, 1'b0, 1'b1);
        chk("captured write bellek[1]", u_g2.bellek[1], 32'h0bad_f00d);
        chk("scrambled addr bellek[2]", u_g2.bellek[2], 32'h0000_2222);

        // Back-to-back requests with istek held high.
        t0 = '{-100, -100, -100};
        t1 = '{-100, -100, -100};
        n0 = 0; n1 = 0;
        @(posedge clk); #1;
        istek = 1'b1; adres = 32'h8000_0000; yaz_gecerli = 1'b0;
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            if (hz[0] && n0 < 3) begin t0[n0] = j; n0++; end
            if (hz[1] && n1 < 3) begin t1[n1] = j; n1++; end
        end
        @(posedge clk); #1;
        istek = 1'b0;
        chk("b2b g2 period 1", 32'(t0[1] - t0[0]), 32'd4);
        chk("b2b g2 period 2", 32'(t0[2] - t0[1]), 32'd4);
        chk("b2b g0 period 1", 32'(t1[1] - t1[0]), 32'd2);
        chk("b2b g0 period 2", 32'(t1[2] - t1[1]), 32'd2);
        repeat (25) @(posedge clk);

        // Asynchronous reset while the write is waiting in BEKLE.
        chk("pre-reset oku_veri g3", rd[2], 32'haae0_0893);
        @(posedge clk); #1;
        istek = 1'b1; adres = 32'h8000_000c; yaz_gecerli = 1'b1; yaz_veri = 32'h1234_5678;
        @(posedge clk); #1;
        istek = 1'b0; yaz_gecerli = 1'b0;
        @(negedge clk); #2;
        rst = 1'b1;
        #1;
        chk("async reset hazir g3", 32'(hz[2]), 32'd0);
        chk("async reset hata g3", 32'(ht[2]), 32'd0);
        chk("async reset oku_veri g3", rd[2], 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        say = '{0, 0, 0, 0};
        for (int j = 0; j < 30; j++) begin
            @(negedge clk);
            for (int s = 0; s < 4; s++) if (hz[s]) say[s]++;
        end
        for (int s = 0; s < 4; s++)
            chk($sformatf("idle hazir count g%0d", GK[s]), 32'(say[s]), 32'd0);
        chk("discarded write g3 bellek[3]", u_g3.bellek[3], 32'h3333_3333);
        chk("discarded write g2 bellek[3]", u_g2.bellek[3], 32'h3333_3333);
        chk("discarded write g15 bellek[3]", u_g15.bellek[3], 32'h3333_3333);
        chk("committed write g0 bellek[3]", u_g0.bellek[3], 32'h1234_5678);

        // Request again after reset release.
        erisim(3, 32'h8000_000c, 1'b0, 32'h0, 32'h3333_3333, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
